// File: rtl/aes_mixcol_seq_if.sv
// Request/response handshake bundle for aes_mixcol_seq: state in, state out.
interface aes_mixcol_seq_if;
    logic         InValid;
    logic         InReady;
    logic         E_D;
    logic [127:0] StIn;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] StOut;

    modport master (
        output InValid, E_D, StIn, OutReady,
        input  InReady, OutValid, StOut
    );

    modport slave (
        input  InValid, E_D, StIn, OutReady,
        output InReady, OutValid, StOut
    );
endinterface

// File: rtl/aes_mixcol_seq.sv
// Sequences a 128-bit AES state through an external 32-bit MixColumns datapath, one column per cycle.
// Optional macro AES_MIXCOL_SKIP_EN adds a Skip input that bypasses the mix for the final round.
module aes_mixcol_seq (
    input  logic            clk,
    input  logic            resetn,
    input  logic            Clr,
`ifdef AES_MIXCOL_SKIP_EN
    input  logic            Skip,
`endif
    aes_mixcol_seq_if.slave bus,
    output logic            MixE_D,
    output logic [31:0]     MixDIn,
    input  logic [31:0]     MixDOut,
    output logic            Busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         mode_q, mode_d;
    logic [127:0] st_in_q, st_in_d;
    logic [127:0] st_out_q, st_out_d;
    // Holds InReady low until the first edge after reset release.
    logic         init_q;
    logic [31:0]  col_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            col_q    <= '0;
            mode_q   <= 1'b0;
            st_in_q  <= '0;
            st_out_q <= '0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            mode_q   <= mode_d;
            st_in_q  <= st_in_d;
            st_out_q <= st_out_d;
            init_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        mode_d   = mode_q;
        st_in_d  = st_in_q;
        st_out_d = st_out_q;
        if (Clr) begin
            state_d = IDLE;
            col_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.InValid && bus.InReady) begin
                        mode_d  = bus.E_D;
                        st_in_d = bus.StIn;
                        col_d   = '0;
`ifdef AES_MIXCOL_SKIP_EN
                        if (Skip) begin
                            st_out_d = bus.StIn;
                            state_d  = DONE;
                        end else begin
                            state_d  = RUN;
                        end
`else
                        state_d = RUN;
`endif
                    end
                end
                RUN: begin
                    case (col_q)
                        2'd0:    st_out_d[127:96] = MixDOut;
                        2'd1:    st_out_d[95:64]  = MixDOut;
                        2'd2:    st_out_d[63:32]  = MixDOut;
                        default: st_out_d[31:0]   = MixDOut;
                    endcase
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.OutReady) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        case (col_q)
            2'd0:    col_sel = st_in_q[127:96];
            2'd1:    col_sel = st_in_q[95:64];
            2'd2:    col_sel = st_in_q[63:32];
            default: col_sel = st_in_q[31:0];
        endcase
    end

    // Datapath input is zero outside RUN so the external mixer stays quiet.
    assign MixDIn       = (state_q == RUN) ? col_sel : '0;
    assign MixE_D       = mode_q;
    assign bus.InReady  = (state_q == IDLE) && init_q;
    assign bus.OutValid = (state_q == DONE);
    assign bus.StOut    = st_out_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Scoreboard bench for aes_mixcol_seq with a behavioural MixColumns datapath attached.
module tb_aes_mixcol_seq;

    logic        clk;
    logic        resetn;
    logic        Clr;
    logic        MixE_D;
    logic [31:0] MixDIn;
    logic [31:0] MixDOut;
    logic        Busy;
`ifdef AES_MIXCOL_SKIP_EN
    logic        Skip;
`endif

    aes_mixcol_seq_if bus ();

    aes_mixcol_seq dut (
        .clk     (clk),
        .resetn  (resetn),
        .Clr     (Clr),
`ifdef AES_MIXCOL_SKIP_EN
        .Skip    (Skip),
`endif
        .bus     (bus),
        .MixE_D  (MixE_D),
        .MixDIn  (MixDIn),
        .MixDOut (MixDOut),
        .Busy    (Busy)
    );

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] ALT_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8, r;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        r  = 8'h00;
        if (c[0]) r = r ^ b;
        if (c[1]) r = r ^ b2;
        if (c[2]) r = r ^ b4;
        if (c[3]) r = r ^ b8;
        return r;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        logic [3:0] k0, k1, k2, k3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        if (inv) begin k0 = 4'd14; k1 = 4'd11; k2 = 4'd13; k3 = 4'd9; end
        else     begin k0 = 4'd2;  k1 = 4'd3;  k2 = 4'd1;  k3 = 4'd1; end
        return {gm(a0,k0) ^ gm(a1,k1) ^ gm(a2,k2) ^ gm(a3,k3),
                gm(a0,k3) ^ gm(a1,k0) ^ gm(a2,k1) ^ gm(a3,k2),
                gm(a0,k2) ^ gm(a1,k3) ^ gm(a2,k0) ^ gm(a3,k1),
                gm(a0,k1) ^ gm(a1,k2) ^ gm(a2,k3) ^ gm(a3,k0)};
    endfunction

    assign MixDOut = mixcol(MixDIn, MixE_D);

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each new OutValid and checks data and latency.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.OutValid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_outvalid: got StOut %h expected no output", bus.StOut);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("stout", bus.StOut, e.data);
                    chk("latency", 128'(cyc - acc_cyc), 128'(e.lat));
                end
            end
            if (bus.InReady || bus.OutValid) chk("mixdin_quiet", {96'd0, MixDIn}, 128'd0);
            if (bus.InValid && bus.InReady && !Clr) acc_cyc <= cyc + 1;
            prev_valid <= bus.OutValid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.InReady && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.InReady) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got InReady 0 expected 1");
        end
    endtask

    task automatic send(input logic ed, input logic [127:0] st, input bit push,
                        input logic [127:0] exp, input int lat);
        exp_t e;
        wait_ready();
        if (push) begin
            e.data = exp;
            e.lat  = lat;
            sbq.push_back(e);
        end
        bus.E_D     = ed;
        bus.StIn    = st;
        bus.InValid = 1'b1;
        @(posedge clk); #1;
        bus.InValid = 1'b0;
    endtask

    initial begin
        int a0, a1, n;
        resetn       = 1'b0;
        Clr          = 1'b0;
        bus.InValid  = 1'b0;
        bus.E_D      = 1'b1;
        bus.StIn     = ALT_IN;
        bus.OutReady = 1'b1;
`ifdef AES_MIXCOL_SKIP_EN
        Skip = 1'b0;
`endif
        #12;
        chk("rst_inready",  {127'd0, bus.InReady},  128'd0);
        chk("rst_outvalid", {127'd0, bus.OutValid}, 128'd0);
        chk("rst_busy",     {127'd0, Busy},         128'd0);
        chk("rst_mixdin",   {96'd0, MixDIn},        128'd0);
        chk("rst_mixe_d",   {127'd0, MixE_D},       128'd0);
        chk("rst_stout",    bus.StOut,              128'd0);
        #11 resetn = 1'b1;
        @(posedge clk); #1;
        chk("inready_after_reset", {127'd0, bus.InReady}, 128'd1);

        send(1'b0, FWD_IN, 1, FWD_OUT, 4);
        send(1'b1, INV_IN, 1, INV_OUT, 4);

        // Back-to-back throughput
        wait_ready();
        send(1'b0, FWD_IN, 1, FWD_OUT, 4);
        a0 = cyc;
        send(1'b1, INV_IN, 1, INV_OUT, 4);
        a1 = cyc;
        chk("throughput", 128'(a1 - a0), 128'd6);

        // Backpressure in DONE
        wait_ready();
        bus.OutReady = 1'b0;
        send(1'b0, FWD_IN, 1, FWD_OUT, 4);
        n = 0;
        while (!bus.OutValid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus.InValid = 1'b1;
            bus.StIn    = ALT_IN;
            chk("bp_outvalid", {127'd0, bus.OutValid}, 128'd1);
            chk("bp_inready",  {127'd0, bus.InReady},  128'd0);
            chk("bp_stout",    bus.StOut,              FWD_OUT);
            @(posedge clk); #1;
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_outvalid", {127'd0, bus.OutValid}, 128'd0);
        chk("bp_release_inready",  {127'd0, bus.InReady},  128'd1);

        // Abort in the second RUN cycle; column 0 already rewritten
        send(1'b1, INV_IN, 0, '0, 0);
        @(posedge clk); #1;
        Clr = 1'b1;
        @(posedge clk); #1;
        Clr = 1'b0;
        chk("abort_busy",    {127'd0, Busy},        128'd0);
        chk("abort_inready", {127'd0, bus.InReady}, 128'd1);
        chk("abort_stout",   bus.StOut, 128'hdb135345_9fdc589d_01010101_c6c6c6c6);
        bus.InValid = 1'b1;
        Clr         = 1'b1;
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        Clr         = 1'b0;
        chk("clr_beats_accept_busy", {127'd0, Busy}, 128'd0);
        repeat (6) @(posedge clk);
        #1;

        // Reset while in RUN
        send(1'b1, INV_IN, 0, '0, 0);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_inready",  {127'd0, bus.InReady},  128'd0);
        chk("midrst_outvalid", {127'd0, bus.OutValid}, 128'd0);
        chk("midrst_busy",     {127'd0, Busy},         128'd0);
        chk("midrst_mixdin",   {96'd0, MixDIn},        128'd0);
        chk("midrst_mixe_d",   {127'd0, MixE_D},       128'd0);
        chk("midrst_stout",    bus.StOut,              128'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        send(1'b0, FWD_IN, 1, FWD_OUT, 4);
        send(1'b1, INV_IN, 1, INV_OUT, 4);

`ifdef AES_MIXCOL_SKIP_EN
        wait_ready();
        Skip = 1'b1;
        send(1'b0, ALT_IN, 1, ALT_IN, 1);
        Skip = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("skip_mixdin", {96'd0, MixDIn}, 128'd0);
            @(posedge clk); #1;
        end
`endif

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mixcol_seq.md
AES_MIXCOL_SEQ -- requirements
Module: aes_mixcol_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port Clr, input, 1 bit: synchronous abort.
REQ-004 The block SHALL have port InValid, input, 1 bit: request valid.
REQ-005 The block SHALL have port InReady, output, 1 bit: request accepted when InValid&InReady.
REQ-006 The block SHALL have port E_D, input, 1 bit: mode; 0 = forward MixColumns, 1 = inverse.
REQ-007 The block SHALL have port StIn, input, 128 bits: AES state; column k = StIn[127-32k -: 32].
REQ-008 The block SHALL have port MixE_D, output, 1 bit: mode to the external 32-bit mix-column datapath.
REQ-009 The block SHALL have port MixDIn, output, 32 bits: column to the datapath.
REQ-010 The block SHALL have port MixDOut, input, 32 bits: combinational datapath result.
REQ-011 The block SHALL have port OutValid, output, 1 bit: result valid.
REQ-012 The block SHALL have port OutReady, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port StOut, output, 128 bits: result, same column order as StIn.
REQ-014 The block SHALL have port Busy, output, 1 bit: high when not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, plus a 2-bit column counter Col.
REQ-016 InReady SHALL be 1 only in IDLE; on accept the block SHALL latch StIn and E_D, set Col=0 and go to RUN.
REQ-017 In RUN, MixDIn SHALL equal latched column Col and MixE_D SHALL equal latched E_D, both driven from registers only.
REQ-018 Each RUN cycle SHALL write MixDOut into StOut column Col and increment Col.
REQ-019 On Col==3, the FSM SHALL go to DONE; DONE SHALL occur exactly 4 cycles after the accept edge.
REQ-020 OutValid SHALL be 1 only in DONE; StOut SHALL be stable while OutValid=1.
REQ-021 On OutValid&OutReady, the FSM SHALL go to IDLE; a new accept SHALL be possible no earlier than the following cycle.
REQ-022 Outside RUN, MixDIn SHALL be 0, holding the datapath inputs quiet.
REQ-023 Clr=1 SHALL force IDLE and Col=0 from any state on the next edge, and StOut SHALL keep its value.
REQ-024 When Clr=1 and InValid=1 occur in the same IDLE cycle, Clr SHALL win and no accept SHALL occur.
REQ-025 Changes to InValid or StIn while not in IDLE SHALL have no effect.
REQ-026 An OutReady held high continuously SHALL give a throughput of 1 state per 6 cycles.

Reset
REQ-027 While resetn=0, state SHALL be IDLE, Col=0, and latched mode/state and StOut SHALL be 0.
REQ-028 While resetn=0, outputs SHALL be InReady=0, OutValid=0, Busy=0, MixDIn=0 and MixE_D=0.
REQ-029 After deassertion of resetn, InReady SHALL be 1 from the first clock edge.
REQ-030 Assertion of resetn mid-RUN or mid-DONE SHALL discard the operation immediately.

Configuration
REQ-031 The macro AES_MIXCOL_SKIP_EN, when defined, SHALL add input port Skip (1 bit), sampled at accept.
REQ-032 With AES_MIXCOL_SKIP_EN defined and Skip=1 (final AES round), the block SHALL copy StIn to StOut and go IDLE->DONE directly, with OutValid 1 cycle after accept and MixDIn held at 0.
REQ-033 With AES_MIXCOL_SKIP_EN undefined, port Skip SHALL be absent and every request SHALL take the 4-column path.

Verification
REQ-034 Forward vector: E_D=0, StIn=db135345_f20a225c_01010101_c6c6c6c6, OutReady=1 -> OutValid 4 cycles after accept, StOut=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-035 Inverse vector: E_D=1, StIn=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8 -> StOut=db135345_f20a225c_d4d4d4d5_2d26314c.
REQ-036 Backpressure: OutReady=0 for 10 cycles in DONE -> OutValid and StOut held, InReady=0, a second InValid ignored; OutReady=1 -> IDLE next cycle.
REQ-037 Abort: Clr=1 at the 2nd RUN cycle -> IDLE next edge, OutValid never asserted; Clr with InValid in IDLE -> no accept.
REQ-038 Reset mid-RUN: resetn low in RUN -> all outputs at reset values asynchronously; the next request after release completes correctly.
REQ-039 With AES_MIXCOL_SKIP_EN defined: Skip=1 with any StIn -> StOut=StIn, OutValid 1 cycle after accept, MixDIn stays 0.
